// File: rtl/i2c_slave_regfile_pkg.sv
// Shared address map, ID constant and 7-segment glyph decode for the I2C slave register file.
package i2c_slave_regfile_pkg;

    localparam logic [7:0] SW_BASE  = 8'h00;
    localparam logic [7:0] LED_BASE = 8'h10;
    localparam logic [7:0] FND_BASE = 8'h20;
    localparam logic [7:0] CTRL     = 8'h30;
    localparam logic [7:0] DP_MASK  = 8'h31;
    localparam logic [7:0] STATUS   = 8'h32;
    localparam logic [7:0] ID       = 8'h3F;

    localparam logic [7:0] ID_VALUE = 8'hA5;

    localparam int CTRL_DISP_EN_BIT = 0;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_SW,
        REG_LED,
        REG_FND,
        REG_CTRL,
        REG_DPM,
        REG_STATUS,
        REG_ID
    } reg_sel_e;

    // Active-low {g,f,e,d,c,b,a}; b and d use the lower-case glyphs.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/i2c_slave_regfile_if.sv
// Byte-wide register bus between the I2C protocol engine (master) and the register file (slave).
interface i2c_slave_regfile_if;

    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wen;
    logic       reg_ren;
    logic [7:0] reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_wen,
        output reg_ren,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_wen,
        input  reg_ren,
        output reg_rdata
    );

endinterface

// File: rtl/i2c_slave_regfile_fnd_scanner.sv
// Time-multiplexed 7-segment scanner: holds each digit SCAN_DIV cycles, outputs registered.
module fnd_scanner
    import i2c_slave_regfile_pkg::*;
#(
    parameter int FND_DIGITS = 4,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [FND_DIGITS*4-1:0] digits,
    input  logic [FND_DIGITS-1:0]   dp_mask,
    input  logic                    disp_en,
    output logic [FND_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(FND_DIGITS);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [FND_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [3:0]            nib;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(FND_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        nib = '0;
        for (int d = 0; d < FND_DIGITS; d++) begin
            if (idx_q == IDX_W'(d)) nib = digits[4*d +: 4];
        end

        // Blanking only gates the outputs; the counter and index keep running.
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (disp_en) begin
            an_d[idx_q] = 1'b0;
            seg_d       = hex_to_seg(nib);
            dp_d        = ~dp_mask[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            an_q  <= '1;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// Memory-mapped register file behind the I2C slave engine: switches, LEDs, FND display, ID.
// Optional switch-change interrupt enabled by defining I2C_SLAVE_REGFILE_SW_IRQ_EN.
module i2c_slave_regfile
    import i2c_slave_regfile_pkg::*;
#(
    parameter int SW_W       = 16,
    parameter int LED_W      = 16,
    parameter int FND_DIGITS = 4,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    i2c_slave_regfile_if.slave    bus,
    input  logic [SW_W-1:0]       SW,
    output logic [LED_W-1:0]      LED,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic [FND_DIGITS-1:0] AN,
    output logic                  irq
);

    localparam int SW_BYTES  = SW_W / 8;
    localparam int LED_BYTES = LED_W / 8;
    localparam int FND_BYTES = FND_DIGITS / 2;

    logic [SW_W-1:0]         sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [LED_W-1:0]        led_q, led_d;
    logic [FND_DIGITS*4-1:0] fnd_q, fnd_d;
    logic                    disp_en_q, disp_en_d;
    logic [FND_DIGITS-1:0]   dp_mask_q, dp_mask_d;

    reg_sel_e                sel;
    logic [3:0]              byte_idx;
    logic                    wr_en;
    logic [7:0]              status_rd;
    logic                    unused_ren;

    assign unused_ren = bus.reg_ren;
    assign wr_en      = bus.reg_wen;

    always_comb begin
        sel      = REG_NONE;
        byte_idx = bus.reg_addr[3:0];
        if (bus.reg_addr[7:4] == SW_BASE[7:4] && {1'b0, byte_idx} < 5'(SW_BYTES))
            sel = REG_SW;
        else if (bus.reg_addr[7:4] == LED_BASE[7:4] && {1'b0, byte_idx} < 5'(LED_BYTES))
            sel = REG_LED;
        else if (bus.reg_addr[7:4] == FND_BASE[7:4] && {1'b0, byte_idx} < 5'(FND_BYTES))
            sel = REG_FND;
        else if (bus.reg_addr == CTRL)
            sel = REG_CTRL;
        else if (bus.reg_addr == DP_MASK)
            sel = REG_DPM;
        else if (bus.reg_addr == STATUS)
            sel = REG_STATUS;
        else if (bus.reg_addr == ID)
            sel = REG_ID;
    end

    // Read path is purely combinational, so a same-cycle read sees the pre-write value.
    always_comb begin
        bus.reg_rdata = 8'h00;
        unique case (sel)
            REG_SW: begin
                for (int i = 0; i < SW_BYTES; i++)
                    if (byte_idx == 4'(i)) bus.reg_rdata = sw_s2_q[8*i +: 8];
            end
            REG_LED: begin
                for (int i = 0; i < LED_BYTES; i++)
                    if (byte_idx == 4'(i)) bus.reg_rdata = led_q[8*i +: 8];
            end
            REG_FND: begin
                for (int i = 0; i < FND_BYTES; i++)
                    if (byte_idx == 4'(i)) bus.reg_rdata = fnd_q[8*i +: 8];
            end
            REG_CTRL:   bus.reg_rdata = {7'b0, disp_en_q};
            REG_DPM:    bus.reg_rdata = 8'(dp_mask_q);
            REG_STATUS: bus.reg_rdata = status_rd;
            REG_ID:     bus.reg_rdata = ID_VALUE;
            default:    bus.reg_rdata = 8'h00;
        endcase
    end

    always_comb begin
        sw_s1_d   = SW;
        sw_s2_d   = sw_s1_q;
        led_d     = led_q;
        fnd_d     = fnd_q;
        disp_en_d = disp_en_q;
        dp_mask_d = dp_mask_q;
        if (wr_en) begin
            for (int i = 0; i < LED_BYTES; i++)
                if (sel == REG_LED && byte_idx == 4'(i)) led_d[8*i +: 8] = bus.reg_wdata;
            for (int i = 0; i < FND_BYTES; i++)
                if (sel == REG_FND && byte_idx == 4'(i)) fnd_d[8*i +: 8] = bus.reg_wdata;
            if (sel == REG_CTRL) disp_en_d = bus.reg_wdata[CTRL_DISP_EN_BIT];
            if (sel == REG_DPM)  dp_mask_d = bus.reg_wdata[FND_DIGITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            led_q     <= '0;
            fnd_q     <= '0;
            disp_en_q <= 1'b1;
            dp_mask_q <= '0;
        end else begin
            sw_s1_q   <= sw_s1_d;
            sw_s2_q   <= sw_s2_d;
            led_q     <= led_d;
            fnd_q     <= fnd_d;
            disp_en_q <= disp_en_d;
            dp_mask_q <= dp_mask_d;
        end
    end

`ifdef I2C_SLAVE_REGFILE_SW_IRQ_EN
    logic [SW_W-1:0] sw_prev_q, sw_prev_d;
    logic            sw_chg_q, sw_chg_d;

    // Set is applied after clear so a coincident change is never lost.
    always_comb begin
        sw_prev_d = sw_s2_q;
        sw_chg_d  = sw_chg_q;
        if (wr_en && sel == REG_STATUS && bus.reg_wdata[0]) sw_chg_d = 1'b0;
        if (sw_s2_q != sw_prev_q) sw_chg_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_prev_q <= '0;
            sw_chg_q  <= 1'b0;
        end else begin
            sw_prev_q <= sw_prev_d;
            sw_chg_q  <= sw_chg_d;
        end
    end

    assign status_rd = {7'b0, sw_chg_q};
    assign irq       = sw_chg_q;
`else
    assign status_rd = 8'h00;
    assign irq       = 1'b0;
`endif

    assign LED = led_q;

    fnd_scanner #(
        .FND_DIGITS (FND_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_fnd_scanner (
        .clk     (clk),
        .rst_n   (rst_n),
        .digits  (fnd_q),
        .dp_mask (dp_mask_q),
        .disp_en (disp_en_q),
        .an      (AN),
        .seg     (SEG),
        .dp      (DP)
    );

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Scoreboard bench for i2c_slave_regfile: directed plan plus randomized register traffic.
module tb_i2c_slave_regfile;
    import i2c_slave_regfile_pkg::*;

    localparam int SW_W       = 16;
    localparam int LED_W      = 16;
    localparam int FND_DIGITS = 4;
    localparam int SCAN_DIV   = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [SW_W-1:0]       sw = '0;
    logic [LED_W-1:0]      led;
    logic [6:0]            seg;
    logic                  dp;
    logic [FND_DIGITS-1:0] an;
    logic                  irq;

    i2c_slave_regfile_if bus();

    i2c_slave_regfile #(
        .SW_W       (SW_W),
        .LED_W      (LED_W),
        .FND_DIGITS (FND_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .SW    (sw),
        .LED   (led),
        .SEG   (seg),
        .DP    (dp),
        .AN    (an),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];

    // Reference model of the architectural registers.
    logic [15:0] m_led;
    logic [3:0]  m_dig[FND_DIGITS];
    logic        m_en;
    logic [3:0]  m_dpm;
    logic [15:0] sw_hist[2];
    int          edges;

    // Snapshot used for the display expectation one cycle later.
    logic [3:0]  s_dig[FND_DIGITS];
    logic        s_en;
    logic [3:0]  s_dpm;

    string glyph_tab[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                             "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] r;
        string s;
        r = 7'h7F;
        s = glyph_tab[v];
        for (int j = 0; j < s.len(); j++) r[s[j] - 8'd97] = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        m_led = '0;
        for (int d = 0; d < FND_DIGITS; d++) m_dig[d] = '0;
        m_en  = 1'b1;
        m_dpm = '0;
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        logic [15:0] t;
        if (a < 8'h02) begin
            t = sw_hist[1] >> (8 * a);
            return t[7:0];
        end
        if (a >= 8'h10 && a < 8'h12) begin
            t = m_led >> (8 * (a - 8'h10));
            return t[7:0];
        end
        if (a >= 8'h20 && a < 8'h22) return {m_dig[2*(a-8'h20)+1], m_dig[2*(a-8'h20)]};
        if (a == 8'h30) return {7'b0, m_en};
        if (a == 8'h31) return {4'b0, m_dpm};
        if (a == 8'h3F) return 8'hA5;
        return 8'h00;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        if (a >= 8'h10 && a < 8'h12) m_led[8*int'(a-8'h10) +: 8] = d;
        else if (a >= 8'h20 && a < 8'h22) begin
            m_dig[2*(a-8'h20)]   = d[3:0];
            m_dig[2*(a-8'h20)+1] = d[7:4];
        end
        else if (a == 8'h30) m_en = d[0];
        else if (a == 8'h31) m_dpm = d[3:0];
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            edges      = 0;
            sw_hist[0] = '0;
            sw_hist[1] = '0;
        end else begin
            edges++;
            sw_hist[1] = sw_hist[0];
            sw_hist[0] = sw;
        end
    end

    // Read monitor: every cycle with reg_ren high consumes one expectation.
    always @(negedge clk) begin
        if (bus.reg_ren) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_underflow: got %0h expected none", bus.reg_rdata);
            end else begin
                logic [7:0] e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, 32'(bus.reg_rdata), 32'(e));
            end
        end
    end

    // Display monitor: digit index follows from elapsed cycles since reset release.
    always @(negedge clk) begin
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int         idx;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (edges > 0 && s_en) begin
            idx   = ((edges - 1) / SCAN_DIV) % FND_DIGITS;
            e_an  = ~(4'b0001 << idx);
            e_seg = glyph(s_dig[idx]);
            e_dp  = ~s_dpm[idx];
        end
        chk("disp", {21'b0, an, seg}, {21'b0, e_an, e_seg});
        chk("disp_dp", 32'(dp), 32'(e_dp));
        s_en  = m_en;
        s_dpm = m_dpm;
        for (int d = 0; d < FND_DIGITS; d++) s_dig[d] = m_dig[d];
    end

    task automatic cyc(input logic [7:0] a, input logic [7:0] wd, input bit w, input bit r);
        bus.reg_addr  = a;
        bus.reg_wdata = wd;
        bus.reg_wen   = w;
        bus.reg_ren   = r;
        if (r) begin
            exp_q.push_back(model_read(a));
            name_q.push_back($sformatf("rd_%02h", a));
        end
        @(posedge clk);
        #1;
        if (w && rst_n) model_write(a, wd);
        bus.reg_wen = 1'b0;
        bus.reg_ren = 1'b0;
    endtask

    task automatic rd_exp(input logic [7:0] a, input logic [7:0] e, input string nm);
        bus.reg_addr = a;
        bus.reg_ren  = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        bus.reg_ren = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] a;
        int         cat;
        bus.reg_addr  = '0;
        bus.reg_wdata = '0;
        bus.reg_wen   = 1'b0;
        bus.reg_ren   = 1'b0;
        model_reset();
        s_en  = 1'b1;
        s_dpm = '0;
        for (int d = 0; d < FND_DIGITS; d++) s_dig[d] = '0;
        idle(3);
        rst_n = 1'b1;

        rd_exp(8'h3F, 8'hA5, "id");
        rd_exp(8'h30, 8'h01, "ctrl_rst");
        rd_exp(8'h10, 8'h00, "led_rst");

        cyc(8'h10, 8'h3C, 1, 0);
        cyc(8'h11, 8'hA5, 1, 0);
        chk("led_pins", 32'(led), 32'h0000A53C);
        rd_exp(8'h10, 8'h3C, "led0");
        rd_exp(8'h11, 8'hA5, "led1");
        cyc(8'h00, 8'hFF, 1, 0);
        rd_exp(8'h00, 8'h00, "sw_ro");

        sw = 16'h1234;
        rd_exp(8'h00, 8'h00, "sw_lat0");
        rd_exp(8'h00, 8'h00, "sw_lat1");
        rd_exp(8'h00, 8'h34, "sw_lo");
        rd_exp(8'h01, 8'h12, "sw_hi");
        cyc(8'h10, 8'h77, 1, 1);
        rd_exp(8'h10, 8'h77, "led_wr");
        rd_exp(8'h55, 8'h00, "unmapped");

        cyc(8'h20, 8'h21, 1, 0);
        cyc(8'h21, 8'h43, 1, 0);
        cyc(8'h31, 8'h04, 1, 0);
        rd_exp(8'h31, 8'h04, "dpm");
        cyc(8'h31, 8'hFF, 1, 1);
        rd_exp(8'h31, 8'h0F, "dpm_raz");
        cyc(8'h31, 8'h04, 1, 0);
        idle(3 * FND_DIGITS * SCAN_DIV);

        cyc(8'h30, 8'h00, 1, 0);
        idle(1);
        chk("blank_an", 32'(an), 32'hF);
        chk("blank_seg", 32'(seg), 32'h7F);
        idle(7);
        cyc(8'h30, 8'h01, 1, 0);
        idle(2 * FND_DIGITS * SCAN_DIV);

`ifdef I2C_SLAVE_REGFILE_SW_IRQ_EN
        cyc(8'h32, 8'h01, 1, 0);
        idle(1);
        chk("irq_clr0", 32'(irq), 32'h0);
        sw = sw ^ 16'h0001;
        idle(3);
        chk("irq_set", 32'(irq), 32'h1);
        rd_exp(8'h32, 8'h01, "status_set");
        cyc(8'h32, 8'h01, 1, 0);
        chk("irq_clr", 32'(irq), 32'h0);
        sw = sw ^ 16'h0001;
        idle(2);
        cyc(8'h32, 8'h01, 1, 0);
        chk("irq_set_wins", 32'(irq), 32'h1);
        idle(1);
        chk("irq_hold", 32'(irq), 32'h1);
`else
        sw = sw ^ 16'h0001;
        idle(4);
        chk("irq_tied", 32'(irq), 32'h0);
        rd_exp(8'h32, 8'h00, "status_raz");
        cyc(8'h32, 8'hFF, 1, 0);
        rd_exp(8'h32, 8'h00, "status_wr_ign");
`endif

        for (int n = 0; n < 400; n++) begin
            cat = $urandom_range(0, 6);
            case (cat)
                0: a = 8'($urandom_range(0, 1));
                1: a = 8'h10 + 8'($urandom_range(0, 1));
                2: a = 8'h20 + 8'($urandom_range(0, 1));
                3: a = 8'h30;
                4: a = 8'h31;
                5: a = 8'h3F;
                default: a = 8'($urandom_range(0, 255));
            endcase
`ifdef I2C_SLAVE_REGFILE_SW_IRQ_EN
            if (a == 8'h32) a = 8'h3F;
`endif
            if ($urandom_range(0, 19) == 0) sw = 16'($urandom);
            cyc(a, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset asserted with a write in flight: the write must be dropped.
        idle(5);
        rst_n = 1'b0;
        cyc(8'h10, 8'hFF, 1, 0);
        model_reset();
        idle(1);
        rst_n = 1'b1;
        rd_exp(8'h10, 8'h00, "led_after_rst");
        rd_exp(8'h30, 8'h01, "ctrl_after_rst");
        rd_exp(8'h20, 8'h00, "fnd_after_rst");
        idle(2 * FND_DIGITS * SCAN_DIV);

        idle(2);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rd_pending: got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Parametrised memory-mapped register file behind the I2C slave protocol engine, replacing the fixed single-digit LED/FND map. It adds the following:
- configurable switch, LED and 7-segment widths;
- a 2-flop switch synchroniser;
- a time-multiplexed multi-digit FND scanner with per-digit decimal points;
- display control and ID registers.

It sits between the protocol's byte-wide register interface and the board I/O.

## Interface
- SW_W, 16, switch input width; multiple of 8, 8..128
- LED_W, 16, LED output width; multiple of 8, 8..128
- FND_DIGITS, 4, number of 7-segment digits; even, 2..8
- SCAN_DIV, 100000, clk cycles each digit is driven; ≥2
- clk  in  1  system clock
- rst_n  in  1  one clock; reset is synchronous and active-low
- reg_addr  in  8  register address from protocol
- reg_wdata  in  8  write data
- reg_wen  in  1  write strobe, one cycle per byte
- reg_ren  in  1  read strobe (informational; read path is combinational)
- reg_rdata  out  8  read data
- SW  in  SW_W  raw asynchronous switches
- LED  out  LED_W  LED drive, active high
- SEG  out  7  segments {g,f,e,d,c,b,a}, active low
- DP  out  1  decimal point, active low
- AN  out  FND_DIGITS  digit anodes, active low, one-hot-low
- irq  out  1  switch-change interrupt (only with macro, see Configuration)

## Operation
- Address map, byte i is little-endian (byte 0 = bits [7:0]):
  - 0x00+i, i<SW_W/8: SW_DATA, read-only, synchronised switches.
  - 0x10+i, i<LED_W/8: LED byte, read/write.
  - 0x20+i, i<FND_DIGITS/2: FND byte i, low nibble = digit 2i, high nibble = digit 2i+1, read/write.
  - 0x30: CTRL, read/write. bit0 DISP_EN (reset 1); bits[7:1] are read-as-zero.
  - 0x31: DP_MASK, read/write, bit d lights the DP on digit d. Bits ≥FND_DIGITS are read-as-zero.
  - 0x32: STATUS, see Configuration.
  - 0x3F: ID, constant 8'hA5.
- Register access:
  - Writes to read-only or unmapped addresses are ignored.
  - Reads of unmapped addresses return 8'h00.
- Switch synchroniser: SW passes through 2 flops (sw_s1, sw_s2). SW_DATA reads return sw_s2.
- Scanner:
  - scan_cnt counts 0..SCAN_DIV-1.
  - At terminal count, digit index increments and wraps from FND_DIGITS-1 to 0.
  - AN, SEG and DP are registered from the current index.
  - SEG decodes the hex nibble 0-F to the standard glyphs; A b C d E F use the lower-case forms for b and d.
- DISP_EN=0: AN all ones, SEG 7'h7F, DP 1. Scanning continues internally.

## Timing
- Reset values: LED 0, all FND bytes 0, CTRL 8'h01, DP_MASK 0, sw_s1/sw_s2 0, scan_cnt 0, digit index 0, AN all ones, SEG 7'h7F, DP 1, irq 0.
- reg_rdata is combinational from reg_addr, with zero latency.
- A write takes effect at the clk edge where reg_wen=1. A read in the same cycle returns the pre-write value.
- SW change becomes visible on SW_DATA 2–3 cycles later.
- Display outputs lag register writes by 1 cycle. The first scan output after reset release is digit 0, one cycle later.
- Each digit is held exactly SCAN_DIV cycles. A full frame is FND_DIGITS×SCAN_DIV cycles.
- Reset asserted mid-scan or mid-write: all state returns to reset values at the next edge, and an in-flight write is dropped.

## Configuration
- Macro: I2C_SLAVE_REGFILE_SW_IRQ_EN.
- Defined:
  - STATUS bit0 SW_CHG is set when sw_s2 differs from its previous-cycle value.
  - SW_CHG is cleared by writing 1 to 0x32 bit0. If set and clear occur in the same cycle, set wins.
  - irq = SW_CHG, registered, reset 0.
- Undefined:
  - STATUS reads 8'h00 and writes to it are ignored.
  - irq is tied to 0.
  - No change-detect logic is present.

## Structure
- Package i2c_slave_regfile_pkg holds:
  - address constants SW_BASE 8'h00, LED_BASE 8'h10, FND_BASE 8'h20, CTRL 8'h30, DP_MASK 8'h31, STATUS 8'h32, ID 8'h3F;
  - ID_VALUE 8'hA5;
  - the CTRL bit index;
  - function hex_to_seg(logic [3:0]) returning active-low 7 bits.
- One sub-module, fnd_scanner: it owns scan_cnt, the digit index, and the AN/SEG/DP output flops. It takes the packed digit nibbles, DP_MASK and DISP_EN.

## Test plan
- Reset, then read 0x3F, 0x30, 0x10 → 8'hA5, 8'h01, 8'h00. Check AN all ones, SEG 7'h7F and DP 1 during reset.
- Write 0x10=8'h3C and 0x11=8'hA5 → LED=16'hA53C. Read back both bytes. Write 0x00=8'hFF → SW_DATA unchanged.
- SW=16'h1234 → 0x00 reads 8'h00 for 2 cycles, then 8'h34; 0x01 reads 8'h12.
- Run with SCAN_DIV=4. Write 0x20=8'h21, 0x21=8'h43, 0x31=8'h04 → AN cycles 1110, 1101, 1011, 0111 every 4 cycles, with SEG glyphs 1, 2, 3, 4. DP=0 only on digit 2.
- Write 0x30=8'h00 → next cycle AN all ones and SEG 7'h7F. Write 0x30=8'h01 → scanning resumes at the current index.
- With the macro defined:
  - toggle SW[0] → irq=1 and STATUS=8'h01;
  - write 0x32=8'h01 → irq=0;
  - toggle SW[0] in the same cycle as the clear write → irq stays 1.
